sevseg_scan: RTL
================

Name: sevseg_scan

Overview:
- Time-multiplexed scanner for a multi-digit common-segment seven-segment display.
- Takes a packed hex value over a valid/ready handshake and buffers it to frame boundaries so the display never tears.
- Drives one nibble at a time to the downstream combinational SevSeg decoder, plus the per-digit enables and the decimal point.
- Inserts a blanking gap between digits (anti-ghosting) and optionally suppresses leading zeros.

Parameters:
- DIGITS, 4, number of display digits (≥2).
- REFRESH_DIV, 27000, clock cycles per digit slot (≥ BLANK_CYCLES+1).
- BLANK_CYCLES, 64, cycles at the start of each slot with all digits off (≥1).
- DIG_ACTIVE_LOW, 1, 1 = dig_en bits are active-low.
- LZ_BLANK, 1, 1 = suppress leading-zero digits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- value  in  4*DIGITS  hex digits; digit 0 = value[3:0] (least significant)
- dp_in  in  DIGITS  decimal-point request per digit, sampled with value
- value_valid  in  1  value/dp_in offered
- value_ready  out  1  pending buffer empty; transfer when valid&&ready
- nibble  out  4  current digit's hex code, to SevSeg data input
- dig_en  out  DIGITS  digit enables, polarity per DIG_ACTIVE_LOW
- dp_n  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse on the commit cycle (end of each frame)

Behaviour:
- Single clock. Reset is asynchronous and active-high (rst); all state is cleared immediately on assertion.
- Reset values:
  - slot counter 0, digit index 0
  - display and pending registers 0, pending empty
  - value_ready=1, nibble=0, dp_n=1, frame_tick=0
  - dig_en all inactive (all 1s if DIG_ACTIVE_LOW, else all 0s)
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments 0..DIGITS-1 and wraps to 0.
  - Scan order is ascending.
  - The first slot after reset release is digit 0, starting at cnt=0.
- Phases within a slot for digit i (all outputs registered; behaviour stated per cycle of cnt):
  - BLANK (cnt < BLANK_CYCLES): dig_en all inactive, dp_n=1; nibble already equals disp[i].
  - SHOW (cnt ≥ BLANK_CYCLES): only dig_en[i] active, unless suppressed; nibble=disp[i]; dp_n=~disp_dp[i].
  - nibble is constant for the whole slot, so the decoder settles during BLANK.
- Leading-zero suppression (LZ_BLANK=1):
  - Digit i>0 is suppressed when disp[i] and every higher digit are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps dig_en inactive and dp_n=1 for its whole slot, even if dp_in was set for it.
- Handshake:
  - value_ready = ~pending_full.
  - On valid&&ready, value and dp_in are stored in pending and pending_full is set.
  - value_valid while not ready is ignored; the source holds.
- Commit cycle: the last cycle of digit DIGITS-1's slot (cnt=REFRESH_DIV-1, index=DIGITS-1).
  - frame_tick=1 on this cycle.
  - If pending_full was set at the start of the cycle: disp←pending, pending_full cleared.
  - The new value is visible from the next slot (digit 0).
- Simultaneous transfer and commit with pending empty: the transfer lands in pending and is committed at the next frame's commit cycle, never bypassed.
- Frame period: DIGITS*REFRESH_DIV cycles; frame_tick period is exactly that.
- Width rules:
  - cnt is $clog2(REFRESH_DIV) bits.
  - The digit index is $clog2(DIGITS) bits and wraps explicitly at DIGITS-1, including non-power-of-2 DIGITS.
- Reset mid-SHOW: dig_en goes inactive asynchronously, and any pending value is discarded.

Decomposition:
- Shared package sevseg_pkg:
  - NIBBLE_W=4
  - DIGITS default
  - dig_en polarity helper function (active-level mapping)
  - typedef for the packed digit vector
- One natural sub-module: sevseg_prescaler (slot counter, digit index, wrap and commit strobes).
  - The scanner keeps the handshake, buffers and output registers.
- The SevSeg decoder is instanced by the parent, not inside this block.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, DIG_ACTIVE_LOW=1, LZ_BLANK=1.
1. Release reset; no input → every frame shows digit 0 only: nibble=0, dig_en=1110 on cnt 2..7 of slot 0; digits 1–3 stay 1111; frame_tick every 32 cycles.
2. Send 0x1234 with dp_in=0010 at cycle 3 → ready low cycles 4..31; commit and frame_tick at cycle 31; from cycle 32 nibble sequence is 4,3,2,1, 8 cycles each; dig_en 1110/1101/1011/0111 on cnt 2..7; dp_n=0 only during digit 1 SHOW.
3. Send 0x0050 → digits 2 and 3 stay 1111; digit 1 shows 5; digit 0 shows 0. Then send 0x0000 → only digit 0 enabled.
4. Back-to-back valids 0xAAAA then 0xBBBB mid-frame → first accepted; second stalls with ready=0 until the commit; 0xAAAA is shown for one full frame before 0xBBBB.
5. Valid 0xC0DE asserted exactly on the commit cycle with pending empty → accepted, not shown in the next frame, shown in the frame after (64 cycles later).
6. Assert rst mid-SHOW of digit 2 with a pending value → dig_en=1111 and dp_n=1 the same cycle without a clock edge; after release, display is 0 and value_ready=1.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the seven-segment scanner.
package sevseg_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int DIGITS_DEF = 4;

    typedef logic [NIBBLE_W-1:0]    nibble_t;
    typedef nibble_t [DIGITS_DEF-1:0] digvec_t;

    // Map a logical "digit on" request to the pin level for the chosen polarity.
    function automatic logic dig_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/sevseg_prescaler.sv
// Slot timer: cycle counter within a digit slot, digit index, and the commit strobe.
// Exposes next-state values so the scanner can register outputs that line up with cnt.
module sevseg_prescaler
    import sevseg_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int REFRESH_DIV = 27000,
    localparam int CNT_W      = $clog2(REFRESH_DIV),
    localparam int IDX_W      = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic [IDX_W-1:0] idx_nxt,
    output logic             commit
);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             last_dig;

    assign wrap     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign last_dig = (idx == IDX_W'(DIGITS - 1));
    assign commit   = wrap && last_dig;

    // Next slot position: counter wraps per slot, index wraps explicitly at DIGITS-1.
    always_comb begin
        cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        idx_nxt = idx;
        if (wrap) begin
            idx_nxt = last_dig ? '0 : idx + IDX_W'(1);
        end
    end

    // Slot position state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/sevseg_scan.sv
// Time-multiplexed seven-segment scanner with frame-aligned value buffering,
// inter-digit blanking and optional leading-zero suppression.
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int DIGITS         = DIGITS_DEF,
    parameter int REFRESH_DIV    = 27000,
    parameter int BLANK_CYCLES   = 64,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int LZ_BLANK       = 1,
    localparam int CNT_W         = $clog2(REFRESH_DIV),
    localparam int IDX_W         = $clog2(DIGITS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NIBBLE_W*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic                       value_valid,
    output logic                       value_ready,
    output logic [NIBBLE_W-1:0]        nibble,
    output logic [DIGITS-1:0]          dig_en,
    output logic                       dp_n,
    output logic                       frame_tick
);

    localparam logic [DIGITS-1:0] EN_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 commit;

    nibble_t [DIGITS-1:0] disp, pend, disp_nxt;
    logic [DIGITS-1:0]    disp_dp, pend_dp, disp_dp_nxt;
    logic                 pend_full;
    logic                 xfer;
    logic                 load;

    logic [DIGITS-1:0]    lz;
    logic                 zacc;
    logic                 show;
    logic [DIGITS-1:0]    en_nxt;

    sevseg_prescaler #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .cnt_nxt (cnt_nxt),
        .idx_nxt (idx_nxt),
        .commit  (commit)
    );

    assign value_ready = ~pend_full;
    assign xfer        = value_valid & ~pend_full;
    // Only a value already pending at the start of the commit cycle is loaded.
    assign load        = commit & pend_full;

    // Display contents as they will be after this edge.
    always_comb begin
        disp_nxt    = load ? pend    : disp;
        disp_dp_nxt = load ? pend_dp : disp_dp;
    end

    // Leading-zero mask: a digit is suppressed when it and every higher digit are zero.
    always_comb begin
        lz   = '0;
        zacc = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zacc = zacc & (disp_nxt[i] == '0);
            if ((LZ_BLANK != 0) && (i > 0)) begin
                lz[i] = zacc;
            end
        end
    end

    // Enable pattern for the upcoming cycle: one digit lit in SHOW unless suppressed.
    always_comb begin
        show = (cnt_nxt >= CNT_W'(BLANK_CYCLES)) && !lz[idx_nxt];
        for (int i = 0; i < DIGITS; i++) begin
            en_nxt[i] = dig_level(show && (idx_nxt == IDX_W'(i)), DIG_ACTIVE_LOW != 0);
        end
    end

    // Handshake buffer and frame-aligned display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp      <= '0;
            disp_dp   <= '0;
            pend      <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else begin
            disp    <= disp_nxt;
            disp_dp <= disp_dp_nxt;
            if (load) begin
                pend_full <= 1'b0;
            end
            if (xfer) begin
                pend      <= value;
                pend_dp   <= dp_in;
                pend_full <= 1'b1;
            end
        end
    end

    // Registered outputs, computed from next-state values so they align with cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nibble     <= '0;
            dig_en     <= EN_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            nibble     <= disp_nxt[idx_nxt];
            dig_en     <= en_nxt;
            dp_n       <= ~(show & disp_dp_nxt[idx_nxt]);
            frame_tick <= (cnt_nxt == CNT_W'(REFRESH_DIV - 1)) && (idx_nxt == IDX_W'(DIGITS - 1));
        end
    end

endmodule
